// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle ALU between NREQ requesters.
// Latches the winning request, runs the ALU for ALU_LAT cycles, returns a tagged response.
module alu_arbiter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned N_ALU   = 4,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned ALU_LAT = 2
) (
   input  logic                            clk,
   input  logic                            arst,
   input  logic [NREQ-1:0]                 req_valid,
   output logic [NREQ-1:0]                 req_ready,
   input  logic [NREQ*WIDTH*N_ALU-1:0]     req_a,
   input  logic [NREQ*WIDTH*N_ALU-1:0]     req_b,
   input  logic [NREQ*3-1:0]               req_sel,
   output logic [WIDTH*N_ALU-1:0]          alu_a,
   output logic [WIDTH*N_ALU-1:0]          alu_b,
   output logic [2:0]                      alu_select,
   output logic                            alu_enable,
   input  logic [WIDTH*N_ALU*8-1:0]        alu_out,
   input  logic                            alu_carry_out,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [$clog2(NREQ)-1:0]         rsp_id,
   output logic [WIDTH*N_ALU*8-1:0]        rsp_data,
   output logic                            rsp_carry,
   output logic                            busy
);

   localparam int unsigned DW  = WIDTH * N_ALU;
   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [CW-1:0]   cnt;
   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  cand;

   logic [DW-1:0]   a_arr   [NREQ];
   logic [DW-1:0]   b_arr   [NREQ];
   logic [2:0]      sel_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign a_arr[i]   = req_a[i*DW +: DW];
      assign b_arr[i]   = req_b[i*DW +: DW];
      assign sel_arr[i] = req_sel[i*3 +: 3];
   end

   // First valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(ptr) + k) % NREQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Grant is combinational so a requester sees acceptance in the same cycle.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && grant_found && !arst) begin
         req_ready = NREQ'(1) << grant_idx;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_select <= '0;
         alu_enable <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         rsp_carry  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  alu_a      <= a_arr[grant_idx];
                  alu_b      <= b_arr[grant_idx];
                  alu_select <= sel_arr[grant_idx];
                  rsp_id     <= grant_idx;
                  ptr        <= IDW'((32'(grant_idx) + 32'd1) % NREQ);
                  cnt        <= '0;
                  alu_enable <= 1'b1;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(ALU_LAT - 1)) begin
                  rsp_data   <= alu_out;
                  rsp_carry  <= alu_carry_out;
                  alu_enable <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               alu_enable <= 1'b0;
               rsp_valid  <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: cycle reference model plus response scoreboard.
// The ALU stand-in only presents a correct result on the final enable cycle.
module tb_alu_arbiter;

   localparam int unsigned WIDTH   = 4;
   localparam int unsigned N_ALU   = 4;
   localparam int unsigned NREQ    = 4;
   localparam int unsigned ALU_LAT = 2;
   localparam int unsigned DW      = WIDTH * N_ALU;
   localparam int unsigned IDW     = $clog2(NREQ);

   logic                 clk;
   logic                 arst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*DW-1:0]   req_a;
   logic [NREQ*DW-1:0]   req_b;
   logic [NREQ*3-1:0]    req_sel;
   logic [DW-1:0]        alu_a;
   logic [DW-1:0]        alu_b;
   logic [2:0]           alu_select;
   logic                 alu_enable;
   logic [DW*8-1:0]      alu_out;
   logic                 alu_carry_out;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [DW*8-1:0]      rsp_data;
   logic                 rsp_carry;
   logic                 busy;

   logic [DW-1:0]        sa [NREQ];
   logic [DW-1:0]        sb [NREQ];
   logic [2:0]           ss [NREQ];

   alu_arbiter #(.WIDTH(WIDTH), .N_ALU(N_ALU), .NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
      .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_enable(alu_enable),
      .alu_out(alu_out), .alu_carry_out(alu_carry_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .busy(busy)
   );

   for (genvar i = 0; i < NREQ; i++) begin : g_drv
      assign req_a[i*DW +: DW] = sa[i];
      assign req_b[i*DW +: DW] = sb[i];
      assign req_sel[i*3 +: 3] = ss[i];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [DW*8:0] act, input logic [DW*8:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Returns {carry, 8 result lanes}; each lane is the 16-bit result xor a lane tag.
   function automatic logic [DW*8:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [2:0] s);
      logic [DW:0]     r;
      logic [DW*8-1:0] d;
      case (s)
         3'd0:    r = {1'b0, a} + {1'b0, b};
         3'd1:    r = {1'b0, a} - {1'b0, b};
         3'd2:    r = {1'b0, a & b};
         3'd3:    r = {1'b0, a | b};
         3'd4:    r = {1'b0, a ^ b};
         3'd5:    r = {1'b0, ~a};
         3'd6:    r = {a, 1'b0};
         default: r = {1'b0, b};
      endcase
      d = '0;
      for (int j = 0; j < 8; j++) d[j*DW +: DW] = r[DW-1:0] ^ DW'(j * 32'h1111);
      return {r[DW], d};
   endfunction

   // ALU stand-in: garbage until the ALU_LAT-th consecutive enable cycle.
   int              en_cnt;
   logic [DW*8:0]   alu_res;
   always_ff @(posedge clk) begin
      if (!alu_enable) en_cnt <= 0;
      else             en_cnt <= en_cnt + 1;
   end
   always_comb begin
      alu_res = alu_f(alu_a, alu_b, alu_select);
      if (alu_enable && en_cnt == int'(ALU_LAT) - 1) {alu_carry_out, alu_out} = alu_res;
      else                                          {alu_carry_out, alu_out} = ~alu_res;
   end

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  a;
      logic [DW-1:0]  b;
      logic [2:0]     sel;
   } exp_t;

   typedef enum int {M_IDLE, M_EXEC, M_RESP} mstate_t;

   exp_t            sb_q[$];
   int              served[$];
   int              acc_cyc[$];
   int              lat_log[$];
   logic [DW*8:0]   res_log[$];
   mstate_t         m_state = M_IDLE;
   int              m_ptr = 0;
   int              m_cnt = 0;
   int              cyc = 0;
   int              hs_cyc = 0;
   int              en_count = 0;
   bit              resp_first = 1'b0;
   logic [NREQ-1:0] hs_last = '0;

   // Reference model and scoreboard, sampled mid-cycle on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         hs_last = '0;
         if (alu_enable) en_count++;
         if (arst) begin
            chk("rst_req_ready", (DW*8+1)'(req_ready), '0);
            chk("rst_alu_enable", (DW*8+1)'(alu_enable), '0);
            chk("rst_rsp_valid", (DW*8+1)'(rsp_valid), '0);
            chk("rst_busy", (DW*8+1)'(busy), '0);
            m_state = M_IDLE; m_ptr = 0; m_cnt = 0; resp_first = 1'b0;
            sb_q.delete();
         end else begin
            case (m_state)
               M_IDLE: begin
                  int g;
                  logic [NREQ-1:0] exp_rdy;
                  g = -1;
                  exp_rdy = '0;
                  for (int k = 0; k < int'(NREQ); k++)
                     if (g < 0 && req_valid[(m_ptr + k) % int'(NREQ)]) g = (m_ptr + k) % int'(NREQ);
                  if (g >= 0) exp_rdy[g] = 1'b1;
                  chk("req_ready", (DW*8+1)'(req_ready), (DW*8+1)'(exp_rdy));
                  chk("idle_alu_enable", (DW*8+1)'(alu_enable), '0);
                  chk("idle_rsp_valid", (DW*8+1)'(rsp_valid), '0);
                  chk("idle_busy", (DW*8+1)'(busy), '0);
                  if (g >= 0) begin
                     exp_t e;
                     e.id = IDW'(g); e.a = sa[g]; e.b = sb[g]; e.sel = ss[g];
                     sb_q.push_back(e);
                     hs_last[g] = 1'b1;
                     m_ptr = (g + 1) % int'(NREQ);
                     m_cnt = 0;
                     hs_cyc = cyc;
                     m_state = M_EXEC;
                  end
               end
               M_EXEC: begin
                  chk("exec_alu_enable", (DW*8+1)'(alu_enable), (DW*8+1)'(1));
                  chk("exec_req_ready", (DW*8+1)'(req_ready), '0);
                  chk("exec_rsp_valid", (DW*8+1)'(rsp_valid), '0);
                  if (sb_q.size() == 0) chk("exec_sb_entry", (DW*8+1)'(0), (DW*8+1)'(1));
                  else begin
                     chk("exec_alu_a", (DW*8+1)'(alu_a), (DW*8+1)'(sb_q[0].a));
                     chk("exec_alu_b", (DW*8+1)'(alu_b), (DW*8+1)'(sb_q[0].b));
                     chk("exec_alu_sel", (DW*8+1)'(alu_select), (DW*8+1)'(sb_q[0].sel));
                  end
                  m_cnt++;
                  if (m_cnt == int'(ALU_LAT)) begin
                     m_state = M_RESP;
                     resp_first = 1'b1;
                  end
               end
               default: begin
                  chk("resp_valid", (DW*8+1)'(rsp_valid), (DW*8+1)'(1));
                  chk("resp_req_ready", (DW*8+1)'(req_ready), '0);
                  chk("resp_alu_enable", (DW*8+1)'(alu_enable), '0);
                  chk("resp_busy", (DW*8+1)'(busy), (DW*8+1)'(1));
                  if (resp_first) begin
                     lat_log.push_back(cyc - hs_cyc);
                     resp_first = 1'b0;
                  end
                  if (sb_q.size() == 0) chk("resp_sb_entry", (DW*8+1)'(0), (DW*8+1)'(1));
                  else begin
                     logic [DW*8:0] r;
                     r = alu_f(sb_q[0].a, sb_q[0].b, sb_q[0].sel);
                     chk("rsp_id", (DW*8+1)'(rsp_id), (DW*8+1)'(sb_q[0].id));
                     chk("rsp_data", (DW*8+1)'(rsp_data), (DW*8+1)'(r[DW*8-1:0]));
                     chk("rsp_carry", (DW*8+1)'(rsp_carry), (DW*8+1)'(r[DW*8]));
                     if (rsp_ready) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        served.push_back(int'(e.id));
                        acc_cyc.push_back(cyc);
                        res_log.push_back({rsp_carry, rsp_data});
                        m_state = M_IDLE;
                     end
                  end
               end
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs_last;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(m_state == M_IDLE && req_valid == '0 && sb_q.size() == 0) && n < budget) begin
         tick();
         n++;
      end
      chk("idle_timeout", (DW*8+1)'(n >= budget), '0);
   endtask

   task automatic wait_rsp(input int budget);
      int n;
      n = 0;
      while (!rsp_valid && n < budget) begin
         tick();
         n++;
      end
      chk("rsp_timeout", (DW*8+1)'(n >= budget), '0);
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2:0] s);
      sa[i] = a; sb[i] = b; ss[i] = s;
      req_valid[i] = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0, e0;
      arst = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '0;
      for (int i = 0; i < int'(NREQ); i++) begin sa[i] = '0; sb[i] = '0; ss[i] = '0; end
      tick();
      tick();
      chk("reset_alu_a", (DW*8+1)'(alu_a), '0);
      chk("reset_alu_b", (DW*8+1)'(alu_b), '0);
      chk("reset_alu_select", (DW*8+1)'(alu_select), '0);
      chk("reset_rsp_id", (DW*8+1)'(rsp_id), '0);
      chk("reset_rsp_data", (DW*8+1)'(rsp_data), '0);
      chk("reset_rsp_carry", (DW*8+1)'(rsp_carry), '0);
      arst = 1'b0;
      tick();

      // Single request; later operand changes must not leak into the result.
      e0 = en_count;
      set_req(1, 16'h0003, 16'h0004, 3'd0);
      tick();
      chk("t1_busy", (DW*8+1)'(busy), (DW*8+1)'(1));
      sa[1] = 16'hDEAD; sb[1] = 16'hBEEF;
      wait_idle(20);
      chk("t1_id", (DW*8+1)'(served[$]), (DW*8+1)'(1));
      chk("t1_latency", (DW*8+1)'(lat_log[$]), (DW*8+1)'(3));
      chk("t1_enable_cycles", (DW*8+1)'(en_count - e0), (DW*8+1)'(2));
      chk("t1_data_lo", (DW*8+1)'(res_log[$][DW-1:0]), (DW*8+1)'(7));
      chk("t1_carry", (DW*8+1)'(res_log[$][DW*8]), '0);

      // All four valid through reset: strict order 0..3, 4 cycles apart.
      arst = 1'b1;
      for (int i = 0; i < int'(NREQ); i++) set_req(i, DW'(i + 1), DW'(i * 16), 3'd0);
      tick();
      tick();
      arst = 1'b0;
      n0 = served.size();
      wait_idle(60);
      for (int i = 0; i < int'(NREQ); i++)
         chk("t2_order", (DW*8+1)'(served[n0 + i]), (DW*8+1)'(i));
      for (int i = 1; i < int'(NREQ); i++)
         chk("t2_spacing", (DW*8+1)'(acc_cyc[n0 + i] - acc_cyc[n0 + i - 1]), (DW*8+1)'(4));

      // Rotation: after serving 2, requester 3 beats requester 0.
      set_req(2, 16'h0100, 16'h0011, 3'd1);
      wait_idle(20);
      n0 = served.size();
      set_req(0, 16'h00F0, 16'h0F0F, 3'd2);
      set_req(3, 16'h8001, 16'h0002, 3'd3);
      wait_idle(40);
      chk("t3_first", (DW*8+1)'(served[n0]), (DW*8+1)'(3));
      chk("t3_second", (DW*8+1)'(served[n0 + 1]), (DW*8+1)'(0));

      // Backpressure: response held 10 cycles, competing request must wait.
      rsp_ready = 1'b0;
      set_req(1, 16'h1234, 16'h0F0F, 3'd4);
      wait_rsp(20);
      set_req(3, 16'h4321, 16'h0001, 3'd5);
      e0 = en_count;
      n0 = served.size();
      for (int i = 0; i < 10; i++) tick();
      chk("t4_no_enable", (DW*8+1)'(en_count - e0), '0);
      chk("t4_no_accept", (DW*8+1)'(served.size() - n0), '0);
      rsp_ready = 1'b1;
      tick();
      chk("t4_done", (DW*8+1)'(rsp_valid), '0);
      wait_idle(20);
      chk("t4_id", (DW*8+1)'(served[n0]), (DW*8+1)'(1));
      chk("t4_next", (DW*8+1)'(served[n0 + 1]), (DW*8+1)'(3));

      // Reset in the cycle after a handshake aborts the transaction.
      n0 = served.size();
      set_req(1, 16'h5555, 16'h1111, 3'd0);
      tick();
      req_valid[2] = 1'b1;
      arst = 1'b1;
      #1;
      chk("t5_enable", (DW*8+1)'(alu_enable), '0);
      chk("t5_busy", (DW*8+1)'(busy), '0);
      chk("t5_req_ready", (DW*8+1)'(req_ready), '0);
      chk("t5_alu_a", (DW*8+1)'(alu_a), '0);
      tick();
      tick();
      arst = 1'b0;
      wait_idle(30);
      chk("t5_count", (DW*8+1)'(served.size() - n0), (DW*8+1)'(1));
      chk("t5_id", (DW*8+1)'(served[$]), (DW*8+1)'(2));

      // Overflow carry on add.
      set_req(0, 16'hFFFF, 16'h0001, 3'd0);
      wait_idle(20);
      chk("t6_carry", (DW*8+1)'(res_log[$][DW*8]), (DW*8+1)'(1));
      chk("t6_data_lo", (DW*8+1)'(res_log[$][DW-1:0]), '0);

      // Random request sets and opcodes.
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            sa[i] = DW'($urandom);
            sb[i] = DW'($urandom);
            ss[i] = 3'($urandom_range(0, 7));
         end
         req_valid = NREQ'($urandom_range(1, 15));
         wait_idle(100);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
